// File: rtl/scan_select_sequencer_if.sv
// Control/status bundle between a display controller and scan_select_sequencer.
// The controller (master) drives run/dir/step/en_in; the sequencer (slave) returns decoder selects and pulses.
interface scan_select_sequencer_if;
    // No valid/ready pair: run, dir and en_in are levels, step is a level whose
    // rising edge is the request, and tick/wrap are single-cycle strobes.
    logic run;
    logic dir;
    logic step;
    logic en_in;
    logic sel_e;
    logic sel_a;
    logic sel_b;
    logic sel_c;
    logic tick;
    logic wrap;

    modport master (
        output run, dir, step, en_in,
        input  sel_e, sel_a, sel_b, sel_c, tick, wrap
    );

    modport slave (
        input  run, dir, step, en_in,
        output sel_e, sel_a, sel_b, sel_c, tick, wrap
    );
endinterface

// File: rtl/scan_select_sequencer.sv
// Row/digit index sequencer driving the enable and select lines of a 3-to-8 decoder.
// Define SCAN_BLANK_EN to hold sel_e low for BLANK_LEN cycles after every index change.
module scan_select_sequencer #(
    parameter int PRESCALE  = 100000,
    parameter int LAST      = 7,
    parameter int BLANK_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    scan_select_sequencer_if.slave        bus,
    output logic                          dbg_state
);
    localparam int              PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [2:0]      IDX_LAST = 3'(LAST);

    if (PRESCALE < 2 || PRESCALE > 1048576) begin : g_bad_prescale
        $error("scan_select_sequencer: PRESCALE must be in 2..2^20");
    end
    if (LAST < 1 || LAST > 7) begin : g_bad_last
        $error("scan_select_sequencer: LAST must be in 1..7");
    end
    if (BLANK_LEN < 1 || BLANK_LEN > 15 || BLANK_LEN >= PRESCALE) begin : g_bad_blank_len
        $error("scan_select_sequencer: BLANK_LEN must be in 1..15 and below PRESCALE");
    end

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          step_d_q, step_d_d;
    logic          sel_e_q, sel_e_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          auto_adv;
    logic          man_adv;
    logic          adv;
    logic          at_wrap;

`ifdef SCAN_BLANK_EN
    localparam logic [3:0] BCNT_LOAD = 4'(BLANK_LEN - 1);
    logic [3:0] bcnt_q, bcnt_d;
`endif

    // Prescaler, edge detect and index arithmetic; step is ignored while running.
    always_comb begin
        auto_adv = bus.run && (pcnt_q == PCNT_MAX);
        man_adv  = !bus.run && bus.step && !step_d_q;
        adv      = auto_adv || man_adv;
        pcnt_d   = (bus.run && (pcnt_q != PCNT_MAX)) ? pcnt_q + 1'b1 : '0;
        step_d_d = bus.step;
        at_wrap  = bus.dir ? (idx_q == 3'd0) : (idx_q == IDX_LAST);
        idx_d    = idx_q;
        if (adv) begin
            if (at_wrap) begin
                idx_d = bus.dir ? IDX_LAST : 3'd0;
            end else begin
                idx_d = bus.dir ? idx_q - 3'd1 : idx_q + 3'd1;
            end
        end
    end

    // Next state: an advance always (re)starts the blank window, even mid-blank.
    always_comb begin
        state_d = SHOW;
`ifdef SCAN_BLANK_EN
        bcnt_d  = bcnt_q;
        if (adv) begin
            state_d = BLANK;
            bcnt_d  = BCNT_LOAD;
        end else if (state_q == BLANK && bcnt_q != 4'd0) begin
            state_d = BLANK;
            bcnt_d  = bcnt_q - 4'd1;
        end
`endif
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        sel_e_d = (state_d == SHOW) ? bus.en_in : 1'b0;
        tick_d  = auto_adv;
        wrap_d  = adv && at_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
`ifdef SCAN_BLANK_EN
            bcnt_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef SCAN_BLANK_EN
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            idx_q    <= 3'd0;
            step_d_q <= 1'b0;
            sel_e_q  <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            step_d_q <= step_d_d;
            sel_e_q  <= sel_e_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.sel_e = sel_e_q;
    assign bus.sel_a = idx_q[2];
    assign bus.sel_b = idx_q[1];
    assign bus.sel_c = idx_q[0];
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign dbg_state = (state_q == BLANK);
endmodule

// File: tb/tb_scan_select_sequencer.sv
// Bench for scan_select_sequencer: two instances (PRESCALE=4/LAST=7 and PRESCALE=8/LAST=5)
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_scan_select_sequencer;
    localparam int PS_A = 4;
    localparam int LS_A = 7;
    localparam int PS_B = 8;
    localparam int LS_B = 5;
    localparam int BL   = 2;
    localparam int PSV [2] = '{PS_A, PS_B};
    localparam int LSV [2] = '{LS_A, LS_B};
`ifdef SCAN_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run   = 1'b0;
    logic dir   = 1'b0;
    logic step  = 1'b0;
    logic en_in = 1'b0;
    logic dbg_a, dbg_b;
    int   errors = 0;
    int   checks = 0;
    logic [2:0] exp_q[$];

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk = ~clk;

    scan_select_sequencer_if if_a ();
    scan_select_sequencer_if if_b ();

    assign if_a.run = run;   assign if_b.run = run;
    assign if_a.dir = dir;   assign if_b.dir = dir;
    assign if_a.step = step; assign if_b.step = step;
    assign if_a.en_in = en_in; assign if_b.en_in = en_in;

    scan_select_sequencer #(.PRESCALE(PS_A), .LAST(LS_A), .BLANK_LEN(BL)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .dbg_state(dbg_a));
    scan_select_sequencer #(.PRESCALE(PS_B), .LAST(LS_B), .BLANK_LEN(BL)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .dbg_state(dbg_b));

    // ---------------- reference model ----------------
    int   m_phase [2];
    int   m_idx   [2];
    int   m_blank [2];
    logic m_tick  [2];
    logic m_wrap  [2];
    logic m_sel_e [2];
    logic m_step_prev;
    logic fire_auto [2];
    logic fire      [2];
    int   blank_next[2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            fire_auto[k] = run && (m_phase[k] == PSV[k] - 1);
            fire[k]      = fire_auto[k] || (!run && step && !m_step_prev);
            if (fire[k]) blank_next[k] = BLANK_ON ? BL : 0;
            else         blank_next[k] = (m_blank[k] > 0) ? m_blank[k] - 1 : 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= 0; m_idx[k] <= 0; m_blank[k] <= 0;
                m_tick[k] <= 1'b0; m_wrap[k] <= 1'b0; m_sel_e[k] <= 1'b0;
            end
            m_step_prev <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= run ? (m_phase[k] + 1) % PSV[k] : 0;
                m_tick[k]  <= fire_auto[k];
                m_wrap[k]  <= fire[k] && (dir ? (m_idx[k] == 0) : (m_idx[k] == LSV[k]));
                if (fire[k])
                    m_idx[k] <= dir ? (m_idx[k] + LSV[k]) % (LSV[k] + 1) : (m_idx[k] + 1) % (LSV[k] + 1);
                m_blank[k] <= blank_next[k];
                m_sel_e[k] <= (blank_next[k] > 0) ? 1'b0 : en_in;
            end
            m_step_prev <= step;
        end
    end

    logic [5:0] obs [2];
    logic [5:0] expv[2];
    assign obs[0] = {if_a.sel_e, if_a.sel_a, if_a.sel_b, if_a.sel_c, if_a.tick, if_a.wrap};
    assign obs[1] = {if_b.sel_e, if_b.sel_a, if_b.sel_b, if_b.sel_c, if_b.tick, if_b.wrap};
    always_comb begin
        for (int k = 0; k < 2; k++)
            expv[k] = {m_sel_e[k], m_idx[k][2:0], m_tick[k], m_wrap[k]};
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; en_in = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++; $display("FAIL reset_outputs dut%0d: got %b want 000000", k, obs[k]);
            end
        end
        checks++;
        if ({dbg_a, dbg_b} !== 2'b00) begin
            errors++; $display("FAIL reset_state: got %b want 00", {dbg_a, dbg_b});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_a.sel_e, if_b.sel_e} !== 2'b11) begin
            errors++; $display("FAIL first_edge_sel_e: got %b want 11", {if_a.sel_e, if_b.sel_e});
        end
    endtask

    task automatic test_auto_up();
        int ticks = 0, wraps = 0;
        logic [2:0] idx_a;
        exp_q.delete();
        for (int i = 0; i <= LS_A; i++) exp_q.push_back(3'((i + 1) % (LS_A + 1)));
        run = 1'b1; dir = 1'b0; en_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL auto_up_model dut%0d cyc%0d: got %b want %b", k, i, obs[k], expv[k]);
                end
            end
            idx_a = {if_a.sel_a, if_a.sel_b, if_a.sel_c};
            if (if_a.wrap) wraps++;
            if (if_a.tick) begin
                ticks++;
                checks++;
                if (exp_q.size() == 0 || idx_a !== exp_q[0]) begin
                    errors++; $display("FAIL auto_up_seq cyc%0d: got idx %0d want %0d", i, idx_a,
                                       (exp_q.size() != 0) ? exp_q[0] : 3'd0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (ticks !== 8) begin errors++; $display("FAIL auto_up_ticks: got %0d want 8", ticks); end
        checks++;
        if (wraps !== 1) begin errors++; $display("FAIL auto_up_wraps: got %0d want 1", wraps); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL auto_up_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_auto_down();
        int ticks = 0, wraps = 0;
        do_reset();
        run = 1'b1; dir = 1'b1; en_in = 1'b1;
        for (int i = 0; i < 6 * PS_B; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL auto_down_model dut%0d cyc%0d: got %b want %b", k, i, obs[k], expv[k]);
                end
            end
            if (if_b.tick) ticks++;
            if (if_b.wrap) begin
                wraps++;
                checks++;
                if ({if_b.sel_a, if_b.sel_b, if_b.sel_c} !== 3'(LS_B)) begin
                    errors++; $display("FAIL auto_down_wrap_idx: got %0d want %0d",
                                       {if_b.sel_a, if_b.sel_b, if_b.sel_c}, LS_B);
                end
            end
        end
        checks++;
        if (ticks !== 6) begin errors++; $display("FAIL auto_down_ticks: got %0d want 6", ticks); end
        checks++;
        if (wraps !== 1) begin errors++; $display("FAIL auto_down_wraps: got %0d want 1", wraps); end
        checks++;
        if ({if_b.sel_a, if_b.sel_b, if_b.sel_c} !== 3'd0) begin
            errors++; $display("FAIL auto_down_final: got %0d want 0", {if_b.sel_a, if_b.sel_b, if_b.sel_c});
        end
    endtask

    task automatic test_manual_step();
        logic [2:0] prev_idx, idx_now;
        logic tick_seen = 1'b0;
        do_reset();
        run = 1'b0; dir = 1'b0; en_in = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(3'((i + 1) % (LS_A + 1)));
        prev_idx = 3'd0;
        for (int j = 0; j < 18; j++) begin
            step = (j < 10) || (j >= 13 && j < 16);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL manual_model dut%0d cyc%0d: got %b want %b", k, j, obs[k], expv[k]);
                end
            end
            if (if_a.tick || if_b.tick) tick_seen = 1'b1;
            idx_now = {if_a.sel_a, if_a.sel_b, if_a.sel_c};
            if (idx_now !== prev_idx) begin
                checks++;
                if (exp_q.size() == 0 || idx_now !== exp_q[0]) begin
                    errors++; $display("FAIL manual_seq cyc%0d: got idx %0d (queue size %0d)", j, idx_now, exp_q.size());
                end
                checks++;
                if (!(j == 0 || j == 13)) begin
                    errors++; $display("FAIL manual_latency: change seen cyc%0d want cyc 0 or 13", j);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                prev_idx = idx_now;
            end
        end
        step = 1'b0;
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL manual_count: %0d advances missing want 0", exp_q.size()); end
        checks++;
        if (tick_seen !== 1'b0) begin errors++; $display("FAIL manual_tick: got %b want 0", tick_seen); end
    endtask

    task automatic test_blanking();
        int low_a = 0, low_b = 0;
        do_reset();
        run = 1'b1; dir = 1'b0; en_in = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL blank_auto_model dut%0d cyc%0d: got %b want %b", k, i, obs[k], expv[k]);
                end
            end
            if (!if_a.sel_e) low_a++;
            if (!if_b.sel_e) low_b++;
        end
        checks++;
        if (low_a !== (BLANK_ON ? 8 : 0)) begin
            errors++; $display("FAIL blank_auto_a: got %0d low cycles want %0d", low_a, BLANK_ON ? 8 : 0);
        end
        checks++;
        if (low_b !== (BLANK_ON ? 4 : 0)) begin
            errors++; $display("FAIL blank_auto_b: got %0d low cycles want %0d", low_b, BLANK_ON ? 4 : 0);
        end
        run = 1'b0;
        repeat (3) @(negedge clk);
        low_a = 0;
        for (int j = 0; j < 8; j++) begin
            step = (j == 0) || (j == 2);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL blank_step_model dut%0d cyc%0d: got %b want %b", k, j, obs[k], expv[k]);
                end
            end
            if (!if_a.sel_e) low_a++;
        end
        step = 1'b0;
        checks++;
        if (low_a !== (BLANK_ON ? 4 : 0)) begin
            errors++; $display("FAIL blank_reload: got %0d low cycles want %0d", low_a, BLANK_ON ? 4 : 0);
        end
    endtask

    task automatic test_en_in();
        int ticks = 0;
        do_reset();
        run = 1'b1; dir = 1'b0;
        for (int j = 0; j < 12; j++) begin
            en_in = !(j >= 5 && j < 7);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++; $display("FAIL en_in_model dut%0d cyc%0d: got %b want %b", k, j, obs[k], expv[k]);
                end
            end
            if (if_a.tick) ticks++;
            if (j == 5 || j == 6 || j == 9) begin
                checks++;
                if (if_a.sel_e !== (j == 9)) begin
                    errors++; $display("FAIL en_in_follow cyc%0d: got %b want %b", j, if_a.sel_e, j == 9);
                end
            end
        end
        en_in = 1'b1;
        checks++;
        if (ticks !== 3) begin errors++; $display("FAIL en_in_ticks: got %0d want 3", ticks); end
    endtask

    task automatic test_reset_mid_blank();
        logic found = 1'b0;
        logic tick_found = 1'b0;
        do_reset();
        run = 1'b1; dir = 1'b0; en_in = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if ({if_a.sel_a, if_a.sel_b, if_a.sel_c} == 3'd6) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_reset_timeout: idx 6 not reached got %0d want 6",
                               {if_a.sel_a, if_a.sel_b, if_a.sel_c});
        end
        checks++;
        if (dbg_a !== BLANK_ON) begin errors++; $display("FAIL mid_reset_in_blank: got %b want %b", dbg_a, BLANK_ON); end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++; $display("FAIL mid_reset_async dut%0d: got %b want 000000", k, obs[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 20 && !tick_found; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({if_a.sel_e, if_a.sel_a, if_a.sel_b, if_a.sel_c} !== 4'b1000) begin
                    errors++; $display("FAIL mid_reset_restart: got %b want 1000",
                                       {if_a.sel_e, if_a.sel_a, if_a.sel_b, if_a.sel_c});
                end
            end
            if (if_a.tick) begin
                tick_found = 1'b1;
                checks++;
                if (n !== PS_A) begin errors++; $display("FAIL mid_reset_period: first tick at %0d want %0d", n, PS_A); end
            end
        end
        checks++;
        if (!tick_found) begin errors++; $display("FAIL mid_reset_tick_timeout: got none want tick by 20"); end
    endtask

    initial begin
        test_reset();
        test_auto_up();
        test_auto_down();
        test_manual_step();
        test_blanking();
        test_en_in();
        test_reset_mid_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
